// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port memory between IF and data requesters.
// Data has priority; IF is forced through after STARVE_MAX consecutive lost cycles.
module imem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              stall_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DLOAD} owner_t;

    owner_t        owner, owner_nxt;
    logic [CW-1:0] starve_cnt;
    logic          if_starved;

    // rst gates the grants so nothing reaches the memory while reset is held
    always_comb begin
        if_starved = if_req && starve_cnt == SMAX;
        d_gnt      = rst && d_req && !if_starved;
        if_gnt     = rst && if_req && !d_gnt;
        stall_if   = rst && if_req && !if_gnt;
        mem_we     = d_gnt && d_we;
        mem_addr   = if_gnt ? if_addr : d_gnt ? d_addr : '0;
        mem_wdata  = d_gnt ? d_wdata : '0;
        owner_nxt  = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_DLOAD : OWN_NONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            owner <= OWN_NONE;
        else
            owner <= owner_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            starve_cnt <= (if_req && !if_gnt) ? ((starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1) : '0;
            if (if_gnt)
                if_rdata <= mem_rdata;
            if (d_gnt && !d_we)
                d_rdata <= mem_rdata;
        end
    end

    assign if_rvalid = owner == OWN_IF;
    assign d_rvalid  = owner == OWN_DLOAD;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model of the arbitration, memory contents and responses.
module tb_imem_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, stall_if, mem_we;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] env_mem [64];

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .stall_if(stall_if), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 1) ? 32'h0000_2083 : (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory the DUT drives: asynchronous read, write at the grant edge
    assign mem_rdata = env_mem[mem_addr];
    initial begin
        for (int i = 0; i < 64; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model: sampled mid-cycle, predicts this cycle's outputs, then advances past the next edge
    initial begin
        logic [DW-1:0] ref_mem [64];
        int            lost = 0;
        int            pend = 0;
        logic [DW-1:0] exp_ir = '0, exp_dr = '0;
        logic          e_d, e_i;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_if_gnt", 64'(if_gnt), 64'd0);
                chk("rst_d_gnt", 64'(d_gnt), 64'd0);
                chk("rst_stall", 64'(stall_if), 64'd0);
                chk("rst_mem_we", 64'(mem_we), 64'd0);
                chk("rst_valids", {if_rvalid, d_rvalid}, 64'd0);
                chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
                lost = 0; pend = 0; exp_ir = '0; exp_dr = '0;
            end else begin
                chk("if_rvalid", 64'(if_rvalid), 64'(pend == 1));
                chk("d_rvalid", 64'(d_rvalid), 64'(pend == 2));
                chk("if_rdata", 64'(if_rdata), 64'(exp_ir));
                chk("d_rdata", 64'(d_rdata), 64'(exp_dr));
                e_d = d_req && !(if_req && lost >= SM);
                e_i = if_req && !e_d;
                chk("if_gnt", 64'(if_gnt), 64'(e_i));
                chk("d_gnt", 64'(d_gnt), 64'(e_d));
                chk("stall_if", 64'(stall_if), 64'(if_req && !e_i));
                chk("mem_we", 64'(mem_we), 64'(e_d && d_we));
                chk("mem_addr", 64'(mem_addr), 64'(e_i ? if_addr : e_d ? d_addr : '0));
                if (!e_i) chk("mem_wdata", 64'(mem_wdata), 64'(e_d ? d_wdata : '0));
                pend = e_i ? 1 : (e_d && !d_we) ? 2 : 0;
                if (e_i) exp_ir = ref_mem[if_addr];
                if (e_d && !d_we) exp_dr = ref_mem[d_addr];
                if (e_d && d_we) ref_mem[d_addr] = d_wdata;
                lost = (if_req && !e_i) ? ((lost < SM) ? lost + 1 : lost) : 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] g8;
        logic [3:0] g4;
        logic       ig, dg;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; if_req = 1'b1; if_addr = 6'd1;
        @(negedge clk);
        chk("lit_if_gnt0", 64'(if_gnt), 64'd1);
        chk("lit_stall0", 64'(stall_if), 64'd0);
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("lit_if_rvalid1", 64'(if_rvalid), 64'd1);
        chk("lit_if_rdata1", 64'(if_rdata), 64'h0000_2083);
        // both requesters held: D,D,D,IF repeating
        step(); if_req = 1'b1; if_addr = 6'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g8[i] = if_gnt;
            step();
        end
        chk("lit_starve_pattern", 64'(g8), 64'h88);
        if_req = 1'b0; d_req = 1'b0;
        // store then load to the same address
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 6'd12; d_wdata = 32'd34;
        @(negedge clk);
        chk("lit_store_we", 64'(mem_we), 64'd1);
        step(); d_we = 1'b0;
        @(negedge clk);
        chk("lit_load_we", 64'(mem_we), 64'd0);
        chk("lit_no_store_rvalid", 64'(d_rvalid), 64'd0);
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("lit_raw_rvalid", 64'(d_rvalid), 64'd1);
        chk("lit_raw_rdata", 64'(d_rdata), 64'd34);
        // two lost cycles, IF drops one cycle, counter must restart
        step(); if_req = 1'b1; if_addr = 6'd9; d_req = 1'b1; d_addr = 6'd3;
        step(); step(); if_req = 1'b0;
        step(); if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g4[i] = if_gnt;
            step();
        end
        chk("lit_drop_pattern", 64'(g4), 64'h8);
        // reset right after an IF grant suppresses its response
        if_req = 1'b1; if_addr = 6'd3; d_req = 1'b0;
        step(); rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("lit_rst_suppress", 64'(if_rvalid), 64'd0);
        step(); rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_addr = 6'd7;
        @(negedge clk);
        chk("lit_post_rst_dgnt", 64'(d_gnt), 64'd1);
        step(); if_req = 1'b0; d_req = 1'b0;
        repeat (6) step();
        // randomized traffic holding requests until granted, with occasional reset pulses
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            ig = if_gnt; dg = d_gnt;
            step();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst = 1'b0;
            if (!if_req || ig || $urandom_range(0, 15) == 0) begin
                if_req = $urandom_range(0, 2) != 0;
                if_addr = AW'($urandom);
            end
            if (!d_req || dg || $urandom_range(0, 15) == 0) begin
                d_req = $urandom_range(0, 2) != 0;
                d_we = $urandom_range(0, 2) == 0;
                d_addr = AW'($urandom_range(0, 7));
                d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
